// File: rtl/bram_router_pkg.sv
// bram_router_pkg: shared sizes and tag types for the BRAM return-path router
package bram_router_pkg;
  localparam int NUM_DEST = 6;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int RD_LAT = 2;
  localparam int DEPTH = 4;
  localparam int DEST_W = 3;
  localparam int CRED_W = $clog2(DEPTH + 1);
  typedef logic [DEST_W-1:0] dest_t;
  typedef struct packed {
    logic  valid;
    dest_t dest;
  } tag_t;
endpackage

// File: rtl/bram_out_fifo.sv
// bram_out_fifo: circular first-word-fall-through FIFO feeding one consumer
module bram_out_fifo #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [W-1:0]         data_in,
  input  logic                 pop,
  output logic [W-1:0]         head,
  output logic                 empty,
  output logic [$clog2(D):0]   count
);
  localparam int PW = $clog2(D);
  logic [W-1:0] mem_q [D];
  logic [W-1:0] mem_d [D];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_pop;
  always_comb begin
    do_pop = pop & (cnt_q != '0);
    mem_d = mem_q;
    if (push) mem_d[wp_q] = data_in;
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = do_pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end
  assign head = mem_q[rp_q];
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/bram_out_router.sv
// bram_out_router: issues BRAM reads for several consumers and routes returning data by tag
module bram_out_router
  import bram_router_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       RD_EN,
  input  logic [ADDR_W-1:0]          RD_ADDR,
  input  logic [DEST_W-1:0]          RD_DEST,
  output logic                       RD_RDY,
  output logic                       RD_ERR,
  output logic                       BRAM_EN,
  output logic [ADDR_W-1:0]          BRAM_ADDR,
  input  logic [DATA_W-1:0]          BRAM_DOUT,
  output logic [NUM_DEST*DATA_W-1:0] DOUT,
  output logic [NUM_DEST-1:0]        VALID,
  input  logic [NUM_DEST-1:0]        READY
);
  logic [CRED_W-1:0] cred_q [NUM_DEST];
  logic [CRED_W-1:0] cred_d [NUM_DEST];
  tag_t tag_q [RD_LAT];
  tag_t tag_d [RD_LAT];
  logic rd_err_q, rd_err_d;
  logic dest_ok, accept;
  logic [2**DEST_W-1:0] cred_ok;
  logic [NUM_DEST-1:0] push, pop, empty;
  logic [DATA_W-1:0] head [NUM_DEST];
  logic [$clog2(DEPTH):0] cnt [NUM_DEST];
  always_comb begin
    dest_ok = RD_DEST < DEST_W'(NUM_DEST);
    cred_ok = '0;
    for (int k = 0; k < NUM_DEST; k++) cred_ok[k] = cred_q[k] != '0;
    // unused destination codes map to zero padding, so they are never ready
    RD_RDY = cred_ok[RD_DEST];
    accept = RD_EN & RD_RDY & ~RST;
    BRAM_EN = accept;
    BRAM_ADDR = RD_ADDR;
    rd_err_d = RD_EN & ~dest_ok;
    tag_d[0] = '{valid: accept, dest: RD_DEST};
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    for (int k = 0; k < NUM_DEST; k++) begin
      pop[k] = VALID[k] & READY[k];
      push[k] = tag_q[RD_LAT-1].valid && tag_q[RD_LAT-1].dest == DEST_W'(k);
      cred_d[k] = cred_q[k] - CRED_W'(accept && RD_DEST == DEST_W'(k)) + CRED_W'(pop[k]);
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_err_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      for (int k = 0; k < NUM_DEST; k++) cred_q[k] <= CRED_W'(DEPTH);
    end else begin
      rd_err_q <= rd_err_d;
      tag_q <= tag_d;
      cred_q <= cred_d;
    end
  end
  assign RD_ERR = rd_err_q;
  for (genvar k = 0; k < NUM_DEST; k++) begin : g_fifo
    bram_out_fifo #(.W(DATA_W), .D(DEPTH)) u_fifo (
      .clk(CLK),
      .rst(RST),
      .push(push[k]),
      .data_in(BRAM_DOUT),
      .pop(pop[k]),
      .head(head[k]),
      .empty(empty[k]),
      .count(cnt[k])
    );
    assign VALID[k] = cnt[k] != '0;
    assign DOUT[k*DATA_W +: DATA_W] = empty[k] ? '0 : head[k];
  end
endmodule

// File: tb/tb_bram_out_router.sv
// tb_bram_out_router: scoreboard bench with a BRAM model and per-destination credit model
module tb_bram_out_router;
  import bram_router_pkg::*;
  logic CLK, RST, RD_EN, RD_RDY, RD_ERR, BRAM_EN;
  logic [ADDR_W-1:0] RD_ADDR, BRAM_ADDR;
  logic [DEST_W-1:0] RD_DEST;
  logic [DATA_W-1:0] BRAM_DOUT;
  logic [NUM_DEST*DATA_W-1:0] DOUT;
  logic [NUM_DEST-1:0] VALID, READY;

  bram_out_router dut (
    .CLK(CLK), .RST(RST), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DEST(RD_DEST),
    .RD_RDY(RD_RDY), .RD_ERR(RD_ERR), .BRAM_EN(BRAM_EN), .BRAM_ADDR(BRAM_ADDR),
    .BRAM_DOUT(BRAM_DOUT), .DOUT(DOUT), .VALID(VALID), .READY(READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  logic [DATA_W-1:0] bram_mem [1024];
  logic [DATA_W-1:0] bpipe [RD_LAT];
  assign BRAM_DOUT = bpipe[RD_LAT-1];
  always @(posedge CLK) begin
    bpipe[0] <= BRAM_EN ? bram_mem[BRAM_ADDR] : $urandom;
    for (int i = 1; i < RD_LAT; i++) bpipe[i] <= bpipe[i-1];
  end

  typedef struct {
    logic [DEST_W-1:0] d;
    logic [DATA_W-1:0] v;
    int due;
  } fl_t;
  fl_t infl[$];
  logic [DATA_W-1:0] vis [NUM_DEST][$];
  int cred [NUM_DEST];
  int cyc = 0;
  logic mon_en = 1'b0;
  logic err_exp = 1'b0;
  logic [NUM_DEST-1:0] exp_valid;
  logic rdy_exp, acc;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) if (mon_en) begin
    for (int k = 0; k < NUM_DEST; k++) exp_valid[k] = vis[k].size() != 0;
    chk("valid", VALID, exp_valid);
    for (int k = 0; k < NUM_DEST; k++)
      if (exp_valid[k]) chk($sformatf("dout%0d", k), DOUT[k*DATA_W +: DATA_W], vis[k][0]);
    chk("rd_err", RD_ERR, err_exp);
    if (RST) begin
      chk("bram_en_rst", BRAM_EN, 0);
      err_exp = 1'b0;
      infl.delete();
      for (int k = 0; k < NUM_DEST; k++) begin
        vis[k].delete();
        cred[k] = DEPTH;
      end
    end else begin
      rdy_exp = (RD_DEST < NUM_DEST) ? (cred[RD_DEST] > 0) : 1'b0;
      chk("rd_rdy", RD_RDY, rdy_exp);
      acc = RD_EN && rdy_exp;
      chk("bram_en", BRAM_EN, acc);
      if (acc) begin
        chk("bram_addr", BRAM_ADDR, RD_ADDR);
        infl.push_back('{d: RD_DEST, v: bram_mem[RD_ADDR], due: cyc + RD_LAT + 1});
        cred[RD_DEST]--;
      end
      err_exp = RD_EN && RD_DEST >= NUM_DEST;
      for (int k = 0; k < NUM_DEST; k++)
        if (exp_valid[k] && READY[k]) begin
          void'(vis[k].pop_front());
          cred[k]++;
        end
      while (infl.size() > 0 && infl[0].due == cyc + 1) begin
        chk("no_full", vis[infl[0].d].size() < DEPTH, 1);
        vis[infl[0].d].push_back(infl[0].v);
        void'(infl.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic at_neg();
    @(negedge CLK);
  endtask
  task automatic req(input int d, input int a);
    step();
    RD_EN = 1'b1;
    RD_DEST = DEST_W'(d);
    RD_ADDR = ADDR_W'(a);
  endtask
  task automatic drain();
    step();
    RD_EN = 1'b0;
    READY = '1;
    repeat (8) step();
    READY = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bram_mem[i] = 32'(i) * 32'h9E3779B1;
    bram_mem[5] = 32'hDEADBEEF;
    for (int i = 16; i < 20; i++) bram_mem[i] = 32'(i);
    for (int k = 0; k < NUM_DEST; k++) cred[k] = DEPTH;
    RST = 1'b1; RD_EN = 1'b0; RD_ADDR = '0; RD_DEST = '0; READY = '0;
    @(posedge CLK);
    #1 mon_en = 1'b1;
    step();
    at_neg();
    chk("reset_valid", VALID, 0);
    chk("reset_dout", DOUT, 0);
    chk("reset_err", RD_ERR, 0);
    // single read to dest 3, data visible RD_LAT+1 cycles after accept
    step();
    RST = 1'b0;
    RD_EN = 1'b1; RD_DEST = 3'd3; RD_ADDR = 10'd5;
    at_neg();
    chk("single_en", BRAM_EN, 1);
    chk("single_addr", BRAM_ADDR, 5);
    step();
    RD_EN = 1'b0;
    step();
    at_neg();
    chk("single_early", VALID, 0);
    step();
    at_neg();
    chk("single_valid", VALID, 6'b001000);
    chk("single_dout", DOUT[3*DATA_W +: DATA_W], 32'hDEADBEEF);
    drain();
    // credit exhaustion on dest 1
    for (int i = 0; i < 5; i++) begin
      req(1, 32 + i);
      at_neg();
      chk("exh_rdy", RD_RDY, i < 4);
      chk("exh_en", BRAM_EN, i < 4);
    end
    step();
    READY = 6'b000010;
    at_neg();
    chk("exh_pop_rdy", RD_RDY, 0);
    step();
    READY = '0;
    at_neg();
    chk("exh_after_pop", RD_RDY, 1);
    drain();
    // dest 4 full, then pop and accept interplay
    for (int i = 0; i < 4; i++) req(4, 64 + i);
    step();
    RD_EN = 1'b0;
    repeat (3) step();
    RD_EN = 1'b1; RD_DEST = 3'd4; RD_ADDR = 10'd72; READY = 6'b010000;
    at_neg();
    chk("c0_pop_rdy", RD_RDY, 0);
    step();
    READY = '0;
    at_neg();
    chk("c0_next_rdy", RD_RDY, 1);
    step();
    at_neg();
    chk("c0_again", RD_RDY, 0);
    step();
    READY = 6'b010000;
    at_neg();
    chk("c0_pop2", RD_RDY, 0);
    step();
    at_neg();
    chk("acc_and_pop", RD_RDY, 1);
    step();
    READY = '0;
    at_neg();
    chk("cred_held", RD_RDY, 1);
    drain();
    // interleave and ordering
    req(0, 16); req(5, 17); req(0, 18); req(2, 19);
    step();
    RD_EN = 1'b0;
    repeat (3) step();
    at_neg();
    chk("il_d0", DOUT[0 +: DATA_W], 32'h10);
    chk("il_d5", DOUT[5*DATA_W +: DATA_W], 32'h11);
    chk("il_d2", DOUT[2*DATA_W +: DATA_W], 32'h13);
    step();
    READY = 6'b000001;
    step();
    READY = '0;
    at_neg();
    chk("il_d0_second", DOUT[0 +: DATA_W], 32'h12);
    drain();
    // invalid destination
    req(6, 3);
    at_neg();
    chk("inv_rdy", RD_RDY, 0);
    chk("inv_en", BRAM_EN, 0);
    step();
    RD_EN = 1'b0;
    at_neg();
    chk("inv_err", RD_ERR, 1);
    step();
    at_neg();
    chk("inv_err_clr", RD_ERR, 0);
    // reset while reads are in flight
    req(2, 48); req(3, 49);
    step();
    RD_EN = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("rst_flight_valid", VALID, 0);
      step();
    end
    RD_EN = 1'b1; RD_DEST = 3'd3; RD_ADDR = 10'd5;
    at_neg();
    chk("post_rst_en", BRAM_EN, 1);
    step();
    RD_EN = 1'b0;
    step();
    step();
    at_neg();
    chk("post_rst_dout", DOUT[3*DATA_W +: DATA_W], 32'hDEADBEEF);
    drain();
    // random mix, checked by the monitor
    repeat (300) begin
      step();
      RD_EN = 1'($urandom_range(0, 1));
      RD_DEST = DEST_W'($urandom_range(0, 6));
      RD_ADDR = ADDR_W'($urandom_range(0, 1023));
      READY = NUM_DEST'($urandom);
    end
    drain();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_out_router.md
Name: bram_out_router

Overview:
- Return-path counterpart of the BRAM input multiplexer: issues BRAM reads on behalf of 6 consumers and routes the returning 32-bit data to the requesting consumer.
- The destination tag travels through a pipeline matched to the BRAM read latency. Each consumer has a FWFT FIFO with valid/ready handshake.
- Per-destination credits make sure returning data can never overflow a consumer FIFO, so the BRAM pipeline never stalls.

Parameters:
- NUM_DEST, 6, number of consumers (destination codes 0..NUM_DEST-1)
- DATA_W, 32, BRAM data width
- ADDR_W, 10, BRAM address width
- RD_LAT, 2, BRAM read latency in cycles, from BRAM_EN to valid BRAM_DOUT (>=1)
- DEPTH, 4, per-destination FIFO depth (power of two, >=2)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- RD_EN  in  1  read request
- RD_ADDR  in  ADDR_W  read address
- RD_DEST  in  3  destination code for the returned data
- RD_RDY  out  1  request accepted this cycle if RD_EN=1
- RD_ERR  out  1  one-cycle pulse: RD_EN with RD_DEST>=NUM_DEST
- BRAM_EN  out  1  BRAM read enable
- BRAM_ADDR  out  ADDR_W  BRAM read address
- BRAM_DOUT  in  DATA_W  BRAM read data, valid RD_LAT cycles after BRAM_EN
- DOUT  out  NUM_DEST*DATA_W  per-consumer data; slice k = FIFO k head
- VALID  out  NUM_DEST  bit k: FIFO k non-empty
- READY  in  NUM_DEST  bit k: consumer k pops the head this cycle

Behaviour:
- Accept condition: accept = RD_EN & (RD_DEST<NUM_DEST) & (credit[RD_DEST]>0).
- RD_RDY is combinational from RD_DEST and the credits. It is valid even when RD_EN=0.
- Invalid destination: RD_RDY=0, no BRAM access, and RD_ERR=1 on the next cycle (registered pulse).
- On accept: BRAM_EN=1 and BRAM_ADDR=RD_ADDR, combinational pass-through in the same cycle. BRAM_EN is 0 otherwise, and BRAM_ADDR is don't-care when BRAM_EN=0.
- Tag pipe: RD_LAT stages of {valid, dest}. Stage 0 loads {accept, RD_DEST}.
- When the last stage is valid, BRAM_DOUT is pushed into FIFO[dest] in that cycle.
- Load-to-use latency: accept at cycle N gives VALID[k]=1 at cycle N+RD_LAT+1, with DOUT slice k already holding the data (FWFT).
- Credits, per destination, reset value DEPTH, range 0..DEPTH:
  - decrement on accept to k
  - increment on pop (VALID[k]&READY[k])
  - accept and pop on the same k in the same cycle: credit unchanged
  - a credit of 0 blocks only destination k; other destinations proceed
- The credit rule guarantees a FIFO push never finds its FIFO full. The bench asserts this, and the design has no overflow path.
- FIFO: circular, DEPTH entries. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop, including when count=1: both happen. The new head is the next entry or the pushed word.
  - READY[k] with VALID[k]=0 is ignored.
- Back-to-back: one accept per cycle is sustained to any mix of destinations while credits allow.
- Reset values: RD_ERR=0, VALID=0, DOUT=0, all tag stages invalid, all FIFOs empty, credits=DEPTH.
  - BRAM_EN follows accept, so it is 0 while RST=1.
  - RD_RDY and RD_EN are ignored while RST=1.
- Reset mid-operation: in-flight tags are discarded. BRAM data returning after reset deasserts is never pushed, because its tag was cleared.

Decomposition:
- Shared package (bram_router_pkg):
  - NUM_DEST, DATA_W, DEST_W=3
  - dest code type
  - tag struct {valid, dest}
  - localparam CRED_W = $clog2(DEPTH+1)
- Sub-module bram_out_fifo: sync FWFT FIFO with push/data_in/pop/head/empty/count. Instantiated NUM_DEST times via generate.
- Top holds the accept logic, tag pipe, credit counters and push decode.

Test Plan:
- Single read: RST low, RD_EN=1, RD_ADDR=5, RD_DEST=3, BRAM returns 0xDEADBEEF → BRAM_EN pulse with addr 5 at cycle N; VALID[3]=1 and DOUT slice 3=0xDEADBEEF at N+3 (RD_LAT=2); no other VALID bit set.
- Credit exhaustion: READY=0, 5 back-to-back reads to dest 1 → first 4 accepted; 5th has RD_RDY=0 and no BRAM_EN; one pop on READY[1] → RD_RDY=1 next cycle, 5th read accepted.
- Interleave and ordering: reads to dests 0,5,0,2 on consecutive cycles, data 0x10,0x11,0x12,0x13 → FIFO0 yields 0x10 then 0x12; FIFO5 yields 0x11; FIFO2 yields 0x13.
- Simultaneous accept and pop: dest 4 with credit 0 and VALID[4]=1; READY[4]=1 together with RD_EN to dest 4 → pop frees a credit; read accepted next cycle; credit[4] stays 0.
- Invalid destination: RD_EN=1, RD_DEST=6 → RD_RDY=0, BRAM_EN=0, RD_ERR=1 for exactly one cycle; credits unchanged.
- Reset mid-flight: accept 2 reads, assert RST for 1 cycle before data returns → VALID stays 0 after reset; credits return to 4; the next read behaves as in the single-read scenario.
